// File: rtl/bp_be_pipe_acc_wb_engine.sv
// ---------------------------------------------------------------------------
// bp_be_pipe_acc_wb_engine
//
// Accelerator write-back engine for the BE accelerator pipe. A small CSR bank
// holds one destination byte address per channel plus stall and block
// counters. Block ops name a channel and wait in a small op FIFO. Each queued
// op is paired with the next wide D$ block. The block is then streamed out as
// fill-width addressed beats. After each capture the channel's destination
// address advances by one block.
//
// Ports
//   clk_i, reset_ni          clock, asynchronous active-low reset
//   cmd_v_i / cmd_ready_o    command handshake (op, idx, data)
//   cmd_op_i                 0 CSR write, 1 CSR read, 2 block op, 3 no-op
//   cmd_idx_i, cmd_data_i    CSR index (or channel), CSR write data
//   rd_v_o, rd_data_o        CSR read result, one cycle after acceptance
//   wide_v_i / wide_ready_o  wide block handshake, wide_data_i payload
//   wb_v_o / wb_ready_and_i  beat handshake; wb_addr_o, wb_data_o, wb_last_o
//   busy_o                   queued op or block still streaming
// ---------------------------------------------------------------------------
module bp_be_pipe_acc_wb_engine #(
  parameter int dpath_width_p   = 64,
  parameter int num_dest_p      = 2,
  parameter int op_els_p        = 2,
  parameter int block_width_p   = 512,
  parameter int fill_width_p    = 64,
  parameter int csr_idx_width_p = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       cmd_v_i,
  output logic                       cmd_ready_o,
  input  logic [1:0]                 cmd_op_i,
  input  logic [csr_idx_width_p-1:0] cmd_idx_i,
  input  logic [dpath_width_p-1:0]   cmd_data_i,
  output logic [dpath_width_p-1:0]   rd_data_o,
  output logic                       rd_v_o,
  input  logic [block_width_p-1:0]   wide_data_i,
  input  logic                       wide_v_i,
  output logic                       wide_ready_o,
  output logic [dpath_width_p-1:0]   wb_addr_o,
  output logic [fill_width_p-1:0]    wb_data_o,
  output logic                       wb_last_o,
  output logic                       wb_v_o,
  input  logic                       wb_ready_and_i,
  output logic                       busy_o
);

  localparam int beats_lp      = block_width_p / fill_width_p;
  localparam int beat_cnt_w_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;
  localparam int op_ptr_w_lp   = (op_els_p > 1) ? $clog2(op_els_p) : 1;
  localparam int op_cnt_w_lp   = $clog2(op_els_p + 1);

  localparam logic [dpath_width_p-1:0]   block_bytes_lp = dpath_width_p'(block_width_p / 8);
  localparam logic [dpath_width_p-1:0]   fill_bytes_lp  = dpath_width_p'(fill_width_p / 8);
  localparam logic [csr_idx_width_p-1:0] stall_idx_lp   = csr_idx_width_p'(num_dest_p);
  localparam logic [csr_idx_width_p-1:0] block_idx_lp   = csr_idx_width_p'(num_dest_p + 1);
  localparam logic [beat_cnt_w_lp-1:0]   last_beat_lp   = beat_cnt_w_lp'(beats_lp - 1);
  localparam logic [op_cnt_w_lp-1:0]     op_full_cnt_lp = op_cnt_w_lp'(op_els_p);

  typedef enum logic [0:0] {
    e_idle = 1'b0,
    e_send = 1'b1
  } state_e;

  state_e                     state_r;
  logic [dpath_width_p-1:0]   dest_r [num_dest_p];
  logic [dpath_width_p-1:0]   stall_cnt_r;
  logic [dpath_width_p-1:0]   block_cnt_r;
  logic [csr_idx_width_p-1:0] op_mem_r [op_els_p];
  logic [op_ptr_w_lp-1:0]     op_wptr_r;
  logic [op_ptr_w_lp-1:0]     op_rptr_r;
  logic [op_cnt_w_lp-1:0]     op_cnt_r;
  logic [block_width_p-1:0]   block_r;
  logic [dpath_width_p-1:0]   wb_addr_r;
  logic [beat_cnt_w_lp-1:0]   beat_cnt_r;
  logic                       rd_v_r;
  logic [dpath_width_p-1:0]   rd_data_r;

  logic                       op_full_s;
  logic                       op_nonempty_s;
  logic                       cmd_acc_s;
  logic                       csr_wr_s;
  logic                       csr_rd_s;
  logic                       op_enq_s;
  logic                       capture_s;
  logic                       beat_hs_s;
  logic                       last_hs_s;
  logic                       stall_s;
  logic [csr_idx_width_p-1:0] head_ch_s;
  logic [dpath_width_p-1:0]   base_s;
  logic [dpath_width_p-1:0]   dest_rd_s;
  logic [dpath_width_p-1:0]   csr_rd_val_s;

  // Circular pointer advance; op_els_p need not be a power of two.
  function automatic logic [op_ptr_w_lp-1:0] ptr_inc(input logic [op_ptr_w_lp-1:0] ptr);
    if (ptr == op_ptr_w_lp'(op_els_p - 1)) begin
      return {op_ptr_w_lp{1'b0}};
    end else begin
      return ptr + op_ptr_w_lp'(1);
    end
  endfunction

  assign op_full_s     = (op_cnt_r == op_full_cnt_lp);
  assign op_nonempty_s = (op_cnt_r != {op_cnt_w_lp{1'b0}});
  assign cmd_acc_s     = cmd_v_i & ~op_full_s;
  assign csr_wr_s      = cmd_acc_s & (cmd_op_i == 2'd0);
  assign csr_rd_s      = cmd_acc_s & (cmd_op_i == 2'd1);
  assign op_enq_s      = cmd_acc_s & (cmd_op_i == 2'd2);
  assign head_ch_s     = op_mem_r[op_rptr_r];
  assign capture_s     = (state_r == e_idle) & op_nonempty_s & wide_v_i;
  assign beat_hs_s     = (state_r == e_send) & wb_ready_and_i;
  assign last_hs_s     = beat_hs_s & (beat_cnt_r == last_beat_lp);
  assign stall_s       = (state_r == e_send) & ~wb_ready_and_i;

  // Base-address lookup for the head op and CSR read mux; out-of-range
  // channels/indices fall through to zero.
  always_comb begin
    base_s    = {dpath_width_p{1'b0}};
    dest_rd_s = {dpath_width_p{1'b0}};
    for (int c = 0; c < num_dest_p; c++) begin
      base_s    = (head_ch_s == csr_idx_width_p'(c)) ? dest_r[c] : base_s;
      dest_rd_s = (cmd_idx_i == csr_idx_width_p'(c)) ? dest_r[c] : dest_rd_s;
    end
    csr_rd_val_s = (cmd_idx_i == stall_idx_lp) ? stall_cnt_r :
                   (cmd_idx_i == block_idx_lp) ? block_cnt_r : dest_rd_s;
  end

  // CSR read response, sampled before any same-cycle CSR update lands.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_v_r    <= 1'b0;
      rd_data_r <= {dpath_width_p{1'b0}};
    end else begin
      rd_v_r <= csr_rd_s;
      if (csr_rd_s) begin
        rd_data_r <= csr_rd_val_s;
      end
    end
  end

  // Op FIFO holding the channel tag of each queued block op.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < op_els_p; i++) begin
        op_mem_r[i] <= {csr_idx_width_p{1'b0}};
      end
      op_wptr_r <= {op_ptr_w_lp{1'b0}};
      op_rptr_r <= {op_ptr_w_lp{1'b0}};
      op_cnt_r  <= {op_cnt_w_lp{1'b0}};
    end else begin
      if (op_enq_s) begin
        op_mem_r[op_wptr_r] <= cmd_idx_i;
        op_wptr_r           <= ptr_inc(op_wptr_r);
      end
      if (capture_s) begin
        op_rptr_r <= ptr_inc(op_rptr_r);
      end
      case ({op_enq_s, capture_s})
        2'b10:   op_cnt_r <= op_cnt_r + op_cnt_w_lp'(1);
        2'b01:   op_cnt_r <= op_cnt_r - op_cnt_w_lp'(1);
        default: op_cnt_r <= op_cnt_r;
      endcase
    end
  end

  // Destination CSRs: a CSR write beats the post-capture auto-advance.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int c = 0; c < num_dest_p; c++) begin
        dest_r[c] <= {dpath_width_p{1'b0}};
      end
    end else begin
      for (int c = 0; c < num_dest_p; c++) begin
        if (csr_wr_s && (cmd_idx_i == csr_idx_width_p'(c))) begin
          dest_r[c] <= cmd_data_i;
        end else if (capture_s && (head_ch_s == csr_idx_width_p'(c))) begin
          dest_r[c] <= dest_r[c] + block_bytes_lp;
        end
      end
    end
  end

  // Performance counters; a CSR write beats a same-cycle increment.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      stall_cnt_r <= {dpath_width_p{1'b0}};
      block_cnt_r <= {dpath_width_p{1'b0}};
    end else begin
      if (csr_wr_s && (cmd_idx_i == stall_idx_lp)) begin
        stall_cnt_r <= cmd_data_i;
      end else if (stall_s) begin
        stall_cnt_r <= stall_cnt_r + dpath_width_p'(1);
      end
      if (csr_wr_s && (cmd_idx_i == block_idx_lp)) begin
        block_cnt_r <= cmd_data_i;
      end else if (last_hs_s) begin
        block_cnt_r <= block_cnt_r + dpath_width_p'(1);
      end
    end
  end

  // IDLE/SEND sequencer. The block is kept in a shift register so the current
  // beat is always its low slice; the address register tracks that beat.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_r    <= e_idle;
      block_r    <= {block_width_p{1'b0}};
      wb_addr_r  <= {dpath_width_p{1'b0}};
      beat_cnt_r <= {beat_cnt_w_lp{1'b0}};
    end else begin
      case (state_r)
        e_idle: begin
          if (capture_s) begin
            block_r    <= wide_data_i;
            wb_addr_r  <= base_s;
            beat_cnt_r <= {beat_cnt_w_lp{1'b0}};
            state_r    <= e_send;
          end
        end
        e_send: begin
          if (beat_hs_s) begin
            block_r    <= block_r >> fill_width_p;
            wb_addr_r  <= wb_addr_r + fill_bytes_lp;
            beat_cnt_r <= beat_cnt_r + beat_cnt_w_lp'(1);
            if (beat_cnt_r == last_beat_lp) begin
              state_r <= e_idle;
            end
          end
        end
        default: state_r <= e_idle;
      endcase
    end
  end

  assign cmd_ready_o  = ~op_full_s;
  assign rd_v_o       = rd_v_r;
  assign rd_data_o    = rd_data_r;
  assign wide_ready_o = (state_r == e_idle) & op_nonempty_s;
  assign wb_v_o       = (state_r == e_send);
  assign wb_addr_o    = wb_addr_r;
  assign wb_data_o    = block_r[fill_width_p-1:0];
  assign wb_last_o    = (state_r == e_send) & (beat_cnt_r == last_beat_lp);
  assign busy_o       = op_nonempty_s | (state_r == e_send);

endmodule

// File: tb/tb_bp_be_pipe_acc_wb_engine.sv
// Directed bench for bp_be_pipe_acc_wb_engine with a queue-based reference
// model checked every cycle, plus literal expectations for key scenarios.
module tb_bp_be_pipe_acc_wb_engine;

  localparam int ND     = 2;
  localparam int OP_ELS = 2;
  localparam int BEATS  = 8;

  logic         clk_i;
  logic         reset_ni;
  logic         cmd_v_i;
  logic         cmd_ready_o;
  logic [1:0]   cmd_op_i;
  logic [3:0]   cmd_idx_i;
  logic [63:0]  cmd_data_i;
  logic [63:0]  rd_data_o;
  logic         rd_v_o;
  logic [511:0] wide_data_i;
  logic         wide_v_i;
  logic         wide_ready_o;
  logic [63:0]  wb_addr_o;
  logic [63:0]  wb_data_o;
  logic         wb_last_o;
  logic         wb_v_o;
  logic         wb_ready_and_i;
  logic         busy_o;

  bp_be_pipe_acc_wb_engine dut (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .cmd_v_i        (cmd_v_i),
    .cmd_ready_o    (cmd_ready_o),
    .cmd_op_i       (cmd_op_i),
    .cmd_idx_i      (cmd_idx_i),
    .cmd_data_i     (cmd_data_i),
    .rd_data_o      (rd_data_o),
    .rd_v_o         (rd_v_o),
    .wide_data_i    (wide_data_i),
    .wide_v_i       (wide_v_i),
    .wide_ready_o   (wide_ready_o),
    .wb_addr_o      (wb_addr_o),
    .wb_data_o      (wb_data_o),
    .wb_last_o      (wb_last_o),
    .wb_v_o         (wb_v_o),
    .wb_ready_and_i (wb_ready_and_i),
    .busy_o         (busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int tests = 0;
  int fails = 0;
  logic run_chk = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic [63:0] m_dest [ND];
  logic [63:0] m_stall = 64'd0;
  logic [63:0] m_blk   = 64'd0;
  logic [3:0]  m_ops[$];
  beat_t       m_beats[$];
  logic        m_rd_v    = 1'b0;
  logic [63:0] m_rd_data = 64'd0;

  logic [63:0] obs_addr[$];
  logic [63:0] obs_data[$];
  logic        obs_last[$];

  function automatic logic [63:0] m_csr(input logic [3:0] idx);
    if (int'(idx) < ND) return m_dest[int'(idx)];
    else if (int'(idx) == ND) return m_stall;
    else if (int'(idx) == ND + 1) return m_blk;
    else return 64'd0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < ND; c++) m_dest[c] = 64'd0;
    m_stall = 64'd0;
    m_blk = 64'd0;
    m_ops.delete();
    m_beats.delete();
    m_rd_v = 1'b0;
    m_rd_data = 64'd0;
  endtask

  task automatic model_step();
    logic acc, cap, hs, stall;
    logic [3:0] ch;
    logic [63:0] base;
    beat_t b;
    acc   = cmd_v_i && (m_ops.size() < OP_ELS);
    cap   = (m_beats.size() == 0) && (m_ops.size() > 0) && wide_v_i;
    hs    = (m_beats.size() > 0) && wb_ready_and_i;
    stall = (m_beats.size() > 0) && !wb_ready_and_i;
    m_rd_v = acc && (cmd_op_i == 2'd1);
    if (m_rd_v) m_rd_data = m_csr(cmd_idx_i);
    if (hs) begin
      if (m_beats[0].last) m_blk = m_blk + 64'd1;
      void'(m_beats.pop_front());
    end
    if (stall) m_stall = m_stall + 64'd1;
    if (cap) begin
      ch = m_ops.pop_front();
      base = (int'(ch) < ND) ? m_dest[int'(ch)] : 64'd0;
      if (int'(ch) < ND) m_dest[int'(ch)] = m_dest[int'(ch)] + 64'd64;
      for (int k = 0; k < BEATS; k++) begin
        b.addr = base + 64'(k * 8);
        b.data = wide_data_i[k*64 +: 64];
        b.last = (k == BEATS - 1);
        m_beats.push_back(b);
      end
    end
    if (acc && cmd_op_i == 2'd0) begin
      if (int'(cmd_idx_i) < ND) m_dest[int'(cmd_idx_i)] = cmd_data_i;
      else if (int'(cmd_idx_i) == ND) m_stall = cmd_data_i;
      else if (int'(cmd_idx_i) == ND + 1) m_blk = cmd_data_i;
    end
    if (acc && cmd_op_i == 2'd2) m_ops.push_back(cmd_idx_i);
  endtask

  initial begin
    for (int c = 0; c < ND; c++) m_dest[c] = 64'd0;
    forever begin
      @(posedge clk_i);
      if (!reset_ni) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk_i);
      if (reset_ni && run_chk) begin
        chk("cmd_ready", cmd_ready_o, m_ops.size() < OP_ELS);
        chk("wide_ready", wide_ready_o, (m_beats.size() == 0) && (m_ops.size() > 0));
        chk("busy", busy_o, (m_beats.size() > 0) || (m_ops.size() > 0));
        chk("rd_v", rd_v_o, m_rd_v);
        if (m_rd_v) chk("rd_data", rd_data_o, m_rd_data);
        chk("wb_v", wb_v_o, m_beats.size() > 0);
        if (m_beats.size() > 0) begin
          chk("wb_addr", wb_addr_o, m_beats[0].addr);
          chk("wb_data", wb_data_o, m_beats[0].data);
          chk("wb_last", wb_last_o, m_beats[0].last);
        end
        if (wb_v_o && wb_ready_and_i) begin
          obs_addr.push_back(wb_addr_o);
          obs_data.push_back(wb_data_o);
          obs_last.push_back(wb_last_o);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  function automatic logic [511:0] mk_block(input logic [63:0] x);
    logic [511:0] b;
    logic [7:0] by;
    for (int k = 0; k < BEATS; k++) begin
      by = 8'((k + 1) * 17);
      b[k*64 +: 64] = {8{by}} ^ x;
    end
    return b;
  endfunction

  task automatic send_cmd(input logic [1:0] op, input logic [3:0] idx, input logic [63:0] data);
    int n;
    n = 0;
    cmd_v_i = 1'b1;
    cmd_op_i = op;
    cmd_idx_i = idx;
    cmd_data_i = data;
    while (!cmd_ready_o && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("cmd_accept_timeout", cmd_ready_o, 64'd1);
    step();
    cmd_v_i = 1'b0;
  endtask

  task automatic csr_read_chk(input logic [3:0] idx, input logic [63:0] exp, input string name);
    send_cmd(2'd1, idx, 64'd0);
    chk({name, "_v"}, rd_v_o, 64'd1);
    chk(name, rd_data_o, exp);
  endtask

  task automatic send_wide(input logic [511:0] b);
    int n;
    n = 0;
    wide_data_i = b;
    wide_v_i = 1'b1;
    while (!wide_ready_o && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("wide_accept_timeout", wide_ready_o, 64'd1);
    step();
    wide_v_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_o || wb_v_o) && n < 300) begin
      step();
      n++;
    end
    chk("idle_reached", busy_o, 64'd0);
  endtask

  task automatic obs_clear();
    obs_addr.delete();
    obs_data.delete();
    obs_last.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_ni = 1'b1;
    cmd_v_i = 1'b0;
    cmd_op_i = 2'd0;
    cmd_idx_i = 4'd0;
    cmd_data_i = 64'd0;
    wide_data_i = 512'd0;
    wide_v_i = 1'b0;
    wb_ready_and_i = 1'b1;
    #1 reset_ni = 1'b0;
    repeat (3) step();
    chk("rst_rd_v", rd_v_o, 64'd0);
    chk("rst_rd_data", rd_data_o, 64'd0);
    chk("rst_wb_v", wb_v_o, 64'd0);
    chk("rst_wb_last", wb_last_o, 64'd0);
    chk("rst_wb_addr", wb_addr_o, 64'd0);
    chk("rst_wb_data", wb_data_o, 64'd0);
    chk("rst_wide_ready", wide_ready_o, 64'd0);
    chk("rst_busy", busy_o, 64'd0);
    chk("rst_cmd_ready", cmd_ready_o, 64'd1);
    reset_ni = 1'b1;
    run_chk = 1'b1;
    step();

    // CSR write/read and unmapped index
    send_cmd(2'd0, 4'd0, 64'h8000_0000);
    csr_read_chk(4'd0, 64'h8000_0000, "rd_dest0");
    csr_read_chk(4'd9, 64'd0, "rd_idx9");

    // single block, no back-pressure
    send_cmd(2'd0, 4'd0, 64'h1000);
    send_cmd(2'd2, 4'd0, 64'd0);
    obs_clear();
    send_wide(mk_block(64'd0));
    wait_idle();
    chk("blk1_beats", obs_addr.size(), 64'd8);
    chk("blk1_addr0", obs_addr[0], 64'h1000);
    chk("blk1_addr7", obs_addr[7], 64'h1038);
    chk("blk1_last7", obs_last[7], 64'd1);
    chk("blk1_last6", obs_last[6], 64'd0);
    chk("blk1_data2", obs_data[2], 64'h3333_3333_3333_3333);
    csr_read_chk(4'd0, 64'h1040, "blk1_dest0");
    csr_read_chk(4'd3, 64'd1, "blk1_blkcnt");

    // block with 3 stall cycles on beat 2
    send_cmd(2'd0, 4'd0, 64'h1000);
    send_cmd(2'd2, 4'd0, 64'd0);
    obs_clear();
    send_wide(mk_block(64'd0));
    step();
    step();
    chk("stall_beat2_addr", wb_addr_o, 64'h1010);
    wb_ready_and_i = 1'b0;
    repeat (3) step();
    chk("stall_beat2_hold", wb_data_o, 64'h3333_3333_3333_3333);
    wb_ready_and_i = 1'b1;
    wait_idle();
    chk("stall_beats", obs_addr.size(), 64'd8);
    chk("stall_addr2", obs_addr[2], 64'h1010);
    csr_read_chk(4'd2, 64'd3, "stall_cnt");
    csr_read_chk(4'd3, 64'd2, "stall_blkcnt");

    // fill the op FIFO, then drain it
    send_cmd(2'd2, 4'd0, 64'd0);
    send_cmd(2'd2, 4'd1, 64'd0);
    chk("full_cmd_ready", cmd_ready_o, 64'd0);
    chk("full_busy", busy_o, 64'd1);
    chk("full_wide_ready", wide_ready_o, 64'd1);
    obs_clear();
    send_wide(mk_block(64'hA5));
    chk("ready_after_pop", cmd_ready_o, 64'd1);
    send_wide(mk_block(64'h5A5A));
    wait_idle();
    chk("drain_beats", obs_addr.size(), 64'd16);
    chk("drain_addr0", obs_addr[0], 64'h1040);
    chk("drain_addr8", obs_addr[8], 64'd0);
    chk("drain_data0", obs_data[0], 64'h1111_1111_1111_11B4);

    // wide data with no op queued is not consumed
    wide_data_i = mk_block(64'd0);
    wide_v_i = 1'b1;
    repeat (3) step();
    chk("noop_wide_ready", wide_ready_o, 64'd0);
    chk("noop_wb_v", wb_v_o, 64'd0);
    wide_v_i = 1'b0;

    // DEST1 wrap
    send_cmd(2'd0, 4'd1, 64'hFFFF_FFFF_FFFF_FFC0);
    send_cmd(2'd2, 4'd1, 64'd0);
    obs_clear();
    send_wide(mk_block(64'h77));
    wait_idle();
    chk("wrap_addr0", obs_addr[0], 64'hFFFF_FFFF_FFFF_FFC0);
    chk("wrap_addr7", obs_addr[7], 64'hFFFF_FFFF_FFFF_FFF8);
    csr_read_chk(4'd1, 64'd0, "wrap_dest1");

    // reserved op and out-of-range channel
    send_cmd(2'd3, 4'd0, 64'hDEAD);
    send_cmd(2'd2, 4'd5, 64'd0);
    obs_clear();
    send_wide(mk_block(64'h1));
    wait_idle();
    chk("ch5_addr0", obs_addr[0], 64'd0);
    chk("ch5_addr7", obs_addr[7], 64'h38);
    csr_read_chk(4'd0, 64'h1080, "ch5_dest0");

    // CSR write to DEST0 in the capture cycle
    send_cmd(2'd0, 4'd0, 64'h1000);
    send_cmd(2'd2, 4'd0, 64'd0);
    obs_clear();
    wide_data_i = mk_block(64'hC3);
    wide_v_i = 1'b1;
    cmd_v_i = 1'b1;
    cmd_op_i = 2'd0;
    cmd_idx_i = 4'd0;
    cmd_data_i = 64'h2000;
    chk("coll_wide_ready", wide_ready_o, 64'd1);
    chk("coll_cmd_ready", cmd_ready_o, 64'd1);
    step();
    wide_v_i = 1'b0;
    cmd_v_i = 1'b0;
    wait_idle();
    chk("coll_addr0", obs_addr[0], 64'h1000);
    csr_read_chk(4'd0, 64'h2000, "coll_dest0");

    // reset in the middle of a block
    send_cmd(2'd2, 4'd0, 64'd0);
    obs_clear();
    send_wide(mk_block(64'd0));
    step();
    reset_ni = 1'b0;
    #1;
    chk("midrst_wb_v", wb_v_o, 64'd0);
    chk("midrst_busy", busy_o, 64'd0);
    chk("midrst_wb_addr", wb_addr_o, 64'd0);
    step();
    step();
    reset_ni = 1'b1;
    repeat (3) step();
    chk("midrst_beats", obs_addr.size(), 64'd1);
    csr_read_chk(4'd0, 64'd0, "midrst_dest0");
    csr_read_chk(4'd1, 64'd0, "midrst_dest1");
    csr_read_chk(4'd2, 64'd0, "midrst_stall");
    csr_read_chk(4'd3, 64'd0, "midrst_blkcnt");

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bp_be_pipe_acc_wb_engine.md
Name: bp_be_pipe_acc_wb_engine

Overview:
Parametrised accelerator write-back engine for the BE accelerator pipe. It holds a CSR bank of num_dest_p destination-address channels plus two performance counters, and queues block ops tagged with a channel. It pairs each op with an incoming wide D$ block, serialises the block into fill-width beats and streams them out as addressed writes. After each capture, the channel's destination address auto-advances by one block.

Parameters:
dpath_width_p, 64, CSR/datapath width; also the write-address width.
num_dest_p, 2, number of destination-address channels (DEST CSRs).
op_els_p, 2, op FIFO depth (≥2).
block_width_p, 512, wide block width in bits.
fill_width_p, 64, output beat width; block_width_p is an integer multiple of it.
csr_idx_width_p, 4, CSR index width; must be ≥ clog2(num_dest_p+2).

Ports:
clk_i  in  1  clock
reset_ni  in  1  reset, asynchronous, active-low
cmd_v_i  in  1  command valid
cmd_ready_o  out  1  command ready (valid/ready handshake)
cmd_op_i  in  2  0=CSR write, 1=CSR read, 2=block op, 3=reserved (accepted, no effect)
cmd_idx_i  in  csr_idx_width_p  CSR index, or channel for block op
cmd_data_i  in  dpath_width_p  CSR write data
rd_data_o  out  dpath_width_p  CSR read data
rd_v_o  out  1  CSR read data valid
wide_data_i  in  block_width_p  wide block from D$
wide_v_i  in  1  wide block valid
wide_ready_o  out  1  wide block accepted this cycle
wb_addr_o  out  dpath_width_p  beat byte address
wb_data_o  out  fill_width_p  beat data
wb_last_o  out  1  final beat of block
wb_v_o  out  1  beat valid
wb_ready_and_i  in  1  downstream ready
busy_o  out  1  engine has pending or in-flight work

Behaviour:
- Reset (asynchronous, on reset_ni low):
  - All CSRs are 0, the op FIFO is empty and the state is IDLE.
  - rd_v_o, wb_v_o, wb_last_o, wide_ready_o and busy_o are 0. rd_data_o, wb_addr_o and wb_data_o are 0.
  - Reset mid-SEND abandons the block; no further beats are emitted.
- CSR map:
  - idx 0..num_dest_p-1 = DEST[c].
  - idx num_dest_p = STALL_CNT.
  - idx num_dest_p+1 = BLOCK_CNT.
  - Other indices read 0; writes to them are ignored.
- Commands:
  - cmd_ready_o = ~op_fifo_full, applied to every op.
  - A command is accepted when cmd_v_i & cmd_ready_o.
  - CSR write takes effect at the next clock edge.
  - CSR read: rd_v_o=1 and rd_data_o=CSR value exactly 1 cycle after acceptance. The value is sampled in the accept cycle, before same-cycle updates.
  - Block op enqueues cmd_idx_i. A channel ≥ num_dest_p is enqueued as-is and uses address 0, with no DEST update.
- State machine IDLE/SEND:
  - wide_ready_o = (state==IDLE) & op_fifo_nonempty. This is independent of wide_v_i.
  - Capture in IDLE when wide_v_i & wide_ready_o:
    - latch the block;
    - base = DEST[ch];
    - pop the op;
    - DEST[ch] += block_width_p/8 (modulo 2^dpath_width_p);
    - beat counter = 0;
    - go to SEND.
  - wide_v_i with no queued op is not consumed (wide_ready_o=0).
  - SEND: wb_v_o=1 from the cycle after capture onward.
    - Beat k: wb_data_o = block[k*fill_width_p +: fill_width_p]; wb_addr_o = base + k*fill_width_p/8.
    - wb_last_o=1 only when k = block_width_p/fill_width_p - 1.
    - The beat counter advances on wb_v_o & wb_ready_and_i.
    - On the last-beat handshake: go to IDLE and BLOCK_CNT += 1.
    - A next capture is possible the cycle after returning to IDLE, so there is 1 bubble between blocks.
  - Outputs are held stable while wb_v_o & ~wb_ready_and_i.
- Counters:
  - STALL_CNT += 1 on every cycle with wb_v_o & ~wb_ready_and_i.
  - Both counters wrap modulo 2^dpath_width_p.
- Simultaneous events:
  - A CSR write to DEST[ch] in the same cycle as a capture on ch: the capture uses the old value, and the CSR write wins (the increment is lost).
  - A CSR write to a counter in the same cycle as its increment: the CSR write wins.
  - A block op enqueue and a pop in the same cycle when the FIFO is full: not accepted (ready is based on the current full flag).
- busy_o = op_fifo_nonempty | (state==SEND).

Test Plan:
- Reset, then CSR write idx0=0x8000_0000, then read idx0 → rd_v_o one cycle after accept, rd_data_o=0x8000_0000. Read idx 9 → 0.
- DEST0=0x1000; block op ch0; wide block with beat k = 0x11*(k+1) replicated; wb_ready_and_i=1 → 8 beats at addr 0x1000..0x1038 step 8, last on beat 7. DEST0 reads 0x1040, BLOCK_CNT=1.
- Same as the previous case, but wb_ready_and_i low for 3 cycles on beat 2 → beat 2 held stable, STALL_CNT=3, 8 beats total.
- op_els_p=2: enqueue 2 block ops with no wide data → cmd_ready_o=0, busy_o=1, wide_ready_o=1. Supply 2 blocks → both drained, cmd_ready_o returns to 1 after the first pop.
- wide_v_i=1 with an empty op FIFO → wide_ready_o=0, no beats. DEST1=0xFFFF_FFFF_FFFF_FFC0 then capture on ch1 → DEST1 wraps to 0.
- CSR write DEST0=0x2000 in the capture cycle of a block on ch0 (old base 0x1000) → beats use 0x1000, DEST0=0x2000 afterwards. Assert reset_ni mid-SEND → wb_v_o=0 immediately, all CSRs 0.
